// File: rtl/digital_gain_agc_if.sv
// rtl/digital_gain_agc_if.sv - sample/sync bus into and out of the gain stage
interface digital_gain_agc_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int NCH   = 4,
  parameter int CNT_W = 9
);
  logic                 ms_in;
  logic                 en_sync_in;
  logic [CNT_W-1:0]     cnt_sync_in;
  logic [NCH*IN_W-1:0]  data_in;
  logic [NCH*OUT_W-1:0] data_out;
  logic                 en_sync_out;
  logic [CNT_W-1:0]     cnt_sync_out;

  modport master (
    output ms_in, en_sync_in, cnt_sync_in, data_in,
    input  data_out, en_sync_out, cnt_sync_out
  );

  modport slave (
    input  ms_in, en_sync_in, cnt_sync_in, data_in,
    output data_out, en_sync_out, cnt_sync_out
  );
endinterface

// File: rtl/digital_gain_agc.sv
// rtl/digital_gain_agc.sv - multi-channel digital gain with frame-synchronous AGC
// Optional: define GAIN_ROUND_EN for round-half-up before saturation (default truncates).
module digital_gain_agc #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16,
  parameter int NCH     = 4,
  parameter int CNT_W   = 9,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  digital_gain_agc_if.slave  bus,
  input  logic               mode_auto,
  input  logic [SHIFT_W-1:0] manual_shift,
  output logic [IN_W-1:0]    max_out,
  output logic               max_valid,
  output logic [SHIFT_W-1:0] shift_used,
  output logic [15:0]        sat_cnt
);

  localparam int               SHIFT_MAX   = IN_W - OUT_W;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX_V = SHIFT_W'(SHIFT_MAX);
  localparam int               SC_W        = $clog2(NCH + 1);

  logic [NCH*IN_W-1:0]  s1_data_q, s1_data_d;
  logic                 s1_en_q, s1_en_d;
  logic [CNT_W-1:0]     s1_cnt_q, s1_cnt_d;
  logic                 s1_ms_q, s1_ms_d;
  logic [NCH*OUT_W-1:0] out_data_q, out_data_d;
  logic                 out_en_q, out_en_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [IN_W-1:0]      run_max_q, run_max_d;
  logic [IN_W-1:0]      max_out_q, max_out_d;
  logic                 max_valid_q, max_valid_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [15:0]          sat_acc_q, sat_acc_d;
  logic [15:0]          sat_cnt_q, sat_cnt_d;

  logic [IN_W-1:0]      cyc_max;
  logic [IN_W-1:0]      x;
  logic [IN_W:0]        scaled;
  logic                 sat_flag;
  logic [SC_W-1:0]      sat_n;
  logic [16:0]          sat_sum;
  logic [SHIFT_W-1:0]   auto_shift;
  int                   bit_len;
  int                   auto_sh;
`ifdef GAIN_ROUND_EN
  logic [IN_W-1:0]      rnd_src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q   <= '0;
      s1_en_q     <= 1'b0;
      s1_cnt_q    <= '0;
      s1_ms_q     <= 1'b0;
      out_data_q  <= '0;
      out_en_q    <= 1'b0;
      out_cnt_q   <= '0;
      run_max_q   <= '0;
      max_out_q   <= '0;
      max_valid_q <= 1'b0;
      shift_q     <= SHIFT_MAX_V;
      sat_acc_q   <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_en_q     <= s1_en_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_ms_q     <= s1_ms_d;
      out_data_q  <= out_data_d;
      out_en_q    <= out_en_d;
      out_cnt_q   <= out_cnt_d;
      run_max_q   <= run_max_d;
      max_out_q   <= max_out_d;
      max_valid_q <= max_valid_d;
      shift_q     <= shift_d;
      sat_acc_q   <= sat_acc_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  always_comb begin
    s1_data_d   = bus.data_in;
    s1_en_d     = bus.en_sync_in;
    s1_cnt_d    = bus.cnt_sync_in;
    s1_ms_d     = bus.ms_in;
    out_en_d    = s1_en_q;
    out_cnt_d   = s1_cnt_q;
    out_data_d  = '0;
    run_max_d   = run_max_q;
    max_out_d   = max_out_q;
    max_valid_d = 1'b0;
    shift_d     = shift_q;
    sat_acc_d   = sat_acc_q;
    sat_cnt_d   = sat_cnt_q;
    cyc_max     = '0;
    x           = '0;
    scaled      = '0;
    sat_flag    = 1'b0;
    sat_n       = '0;
    bit_len     = 0;
    auto_sh     = 0;
`ifdef GAIN_ROUND_EN
    rnd_src     = '0;
`endif

    // Peak of this cycle's valid samples across all channels.
    for (int k = 0; k < NCH; k++) begin
      if (bus.data_in[k*IN_W +: IN_W] > cyc_max) cyc_max = bus.data_in[k*IN_W +: IN_W];
    end
    if (!bus.en_sync_in) cyc_max = '0;

    for (int i = 0; i < IN_W; i++) begin
      if (run_max_q[i]) bit_len = i + 1;
    end
    auto_sh = bit_len - OUT_W;
    if (auto_sh < 0) auto_sh = 0;
    if (auto_sh > SHIFT_MAX) auto_sh = SHIFT_MAX;
    auto_shift = SHIFT_W'(auto_sh);

    if (bus.ms_in) begin
      max_out_d   = run_max_q;
      max_valid_d = 1'b1;
      run_max_d   = cyc_max;
      if (mode_auto) shift_d = auto_shift;
      else           shift_d = (manual_shift > SHIFT_MAX_V) ? SHIFT_MAX_V : manual_shift;
    end else if (cyc_max > run_max_q) begin
      run_max_d = cyc_max;
    end

    for (int k = 0; k < NCH; k++) begin
      x      = s1_data_q[k*IN_W +: IN_W];
      scaled = {1'b0, x >> shift_q};
`ifdef GAIN_ROUND_EN
      if (shift_q != '0) begin
        rnd_src = x >> (shift_q - 1'b1);
        scaled  = scaled + {{IN_W{1'b0}}, rnd_src[0]};
      end
`endif
      sat_flag = |scaled[IN_W:OUT_W];
      out_data_d[k*OUT_W +: OUT_W] = sat_flag ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
      if (sat_flag && s1_en_q) sat_n = sat_n + SC_W'(1);
    end

    // The frame-start sample sits in S1 here; its registered result lines up with ms delayed 2.
    sat_sum = {1'b0, sat_acc_q} + 17'(sat_n);
    if (s1_ms_q) begin
      sat_cnt_d = sat_acc_q;
      sat_acc_d = 16'(sat_n);
    end else begin
      sat_acc_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign bus.data_out     = out_data_q;
  assign bus.en_sync_out  = out_en_q;
  assign bus.cnt_sync_out = out_cnt_q;
  assign max_out          = max_out_q;
  assign max_valid        = max_valid_q;
  assign shift_used       = shift_q;
  assign sat_cnt          = sat_cnt_q;

endmodule

// File: tb/tb_digital_gain_agc.sv
// tb/tb_digital_gain_agc.sv - randomized and directed bench for digital_gain_agc
module tb_digital_gain_agc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_auto = 1'b1;
  logic [4:0] manual_shift = '0;
  logic [31:0] max_out;
  logic        max_valid;
  logic [4:0]  shift_used;
  logic [15:0] sat_cnt;

  digital_gain_agc_if #(.IN_W(32), .OUT_W(16), .NCH(4), .CNT_W(9)) bus_if ();

  digital_gain_agc #(.IN_W(32), .OUT_W(16), .NCH(4), .CNT_W(9), .SHIFT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .mode_auto    (mode_auto),
    .manual_shift (manual_shift),
    .max_out      (max_out),
    .max_valid    (max_valid),
    .shift_used   (shift_used),
    .sat_cnt      (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        en;
    logic [8:0]  cnt;
    bit          sat_upd;
    int unsigned sat_val;
  } exp_t;

  exp_t            pipe_q[$];
  int unsigned     n_chk = 0;
  int unsigned     n_pass = 0;
  int unsigned     m_shift;
  longint unsigned m_run_max;
  int unsigned     m_frame_sat;
  longint unsigned exp_max_out;
  bit              exp_max_valid;
  int unsigned     exp_sat_cnt;
  int unsigned     cnt_ctr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int unsigned auto_shift_of(input longint unsigned peak);
    int unsigned bl = 0;
    longint unsigned v = peak;
    while (v != 0) begin
      bl++;
      v = v >> 1;
    end
    if (bl <= 16) return 0;
    return (bl - 16 > 16) ? 16 : bl - 16;
  endfunction

  function automatic longint unsigned scale(input longint unsigned s_in, input int unsigned s);
    longint unsigned v = s_in >> s;
`ifdef GAIN_ROUND_EN
    if (s > 0) v = v + ((s_in >> (s - 1)) & 1);
`endif
    return v;
  endfunction

  function automatic logic [127:0] rep4(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  task automatic model_reset();
    exp_t z;
    z.data = '0; z.en = 1'b0; z.cnt = '0; z.sat_upd = 1'b0; z.sat_val = 0;
    pipe_q.delete();
    pipe_q.push_back(z);
    m_shift = 16; m_run_max = 0; m_frame_sat = 0;
    exp_max_out = 0; exp_max_valid = 1'b0; exp_sat_cnt = 0;
  endtask

  task automatic check_outputs(input string pfx);
    exp_t e;
    e = pipe_q.pop_front();
    if (e.sat_upd) exp_sat_cnt = e.sat_val;
    chk({pfx, "_data_out"}, bus_if.data_out, e.data);
    chk({pfx, "_en_out"}, 64'(bus_if.en_sync_out), 64'(e.en));
    chk({pfx, "_cnt_out"}, 64'(bus_if.cnt_sync_out), 64'(e.cnt));
    chk({pfx, "_max_out"}, 64'(max_out), exp_max_out);
    chk({pfx, "_max_valid"}, 64'(max_valid), 64'(exp_max_valid));
    chk({pfx, "_shift"}, 64'(shift_used), 64'(m_shift));
    chk({pfx, "_sat_cnt"}, 64'(sat_cnt), 64'(exp_sat_cnt));
  endtask

  task automatic tick(input bit ms, input bit en, input logic [127:0] data);
    exp_t e;
    longint unsigned cyc = 0;
    longint unsigned ch;
    longint unsigned v;
    int unsigned nsat = 0;
    @(negedge clk);
    bus_if.ms_in       = ms;
    bus_if.en_sync_in  = en;
    bus_if.cnt_sync_in = cnt_ctr[8:0];
    bus_if.data_in     = data;
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        ch = data[k*32 +: 32];
        if (ch > cyc) cyc = ch;
      end
    end
    if (ms) begin
      m_shift = mode_auto ? auto_shift_of(m_run_max) : ((manual_shift > 16) ? 16 : manual_shift);
      exp_max_out = m_run_max;
      exp_max_valid = 1'b1;
      m_run_max = cyc;
    end else begin
      exp_max_valid = 1'b0;
      if (cyc > m_run_max) m_run_max = cyc;
    end
    e.data = '0;
    for (int k = 0; k < 4; k++) begin
      v = scale(data[k*32 +: 32], m_shift);
      if (v > 65535) begin
        v = 65535;
        if (en) nsat++;
      end
      e.data[k*16 +: 16] = v[15:0];
    end
    e.en = en;
    e.cnt = cnt_ctr[8:0];
    e.sat_upd = ms;
    e.sat_val = m_frame_sat;
    if (ms) m_frame_sat = nsat;
    else m_frame_sat = (m_frame_sat + nsat > 65535) ? 65535 : m_frame_sat + nsat;
    pipe_q.push_back(e);
    cnt_ctr++;
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.ms_in = 1'b0; bus_if.en_sync_in = 1'b0;
    bus_if.cnt_sync_in = '0; bus_if.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_data_out", bus_if.data_out, 64'h0);
    chk("rst_shift", 64'(shift_used), 64'd16);
    chk("rst_max_out", 64'(max_out), 64'h0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'h0);
  endtask

  initial begin
    logic [127:0] d;
    model_reset();
    do_reset();

    // 1: full-scale input with the reset shift
    mode_auto = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, rep4(32'hFFFF_FFFF));
    chk("t1_shift", 64'(shift_used), 64'd16);
    chk("t1_data", bus_if.data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_sat", 64'(sat_cnt), 64'd0);

    // 2: peak 0x12345 on channel 2 gives shift 1
    tick(1'b1, 1'b0, '0);
    d = {32'h0000_0100, 32'h0001_2345, 32'h0000_0005, 32'h0000_1000};
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, d);
    tick(1'b1, 1'b1, rep4(32'h0001_2345));
    chk("t2_max_out", 64'(max_out), 64'h0001_2345);
    chk("t2_max_valid", 64'(max_valid), 64'd1);
    chk("t2_shift", 64'(shift_used), 64'd1);
    tick(1'b0, 1'b0, '0);
`ifdef GAIN_ROUND_EN
    chk("t2_data", bus_if.data_out, {4{16'h91A3}});
`else
    chk("t2_data", bus_if.data_out, {4{16'h91A2}});
`endif

    // 3: frame peaks 0x8000, 0, 0xFFFFFFFF
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, rep4(32'h0000_8000));
    tick(1'b1, 1'b0, '0);
    chk("t3_shift_a", 64'(shift_used), 64'd0);
    tick(1'b0, 1'b0, rep4(32'hFFFF_FFFF));
    tick(1'b1, 1'b0, '0);
    chk("t3_shift_b", 64'(shift_used), 64'd0);
    tick(1'b0, 1'b1, rep4(32'hFFFF_FFFF));
    tick(1'b1, 1'b0, '0);
    chk("t3_shift_c", 64'(shift_used), 64'd16);

    // 4: manual shift 4 saturating 40 channel-samples
    mode_auto = 1'b0; manual_shift = 5'd4;
    tick(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, rep4(32'h0010_0000));
    tick(1'b1, 1'b0, '0);
    chk("t4_data", bus_if.data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(1'b0, 1'b0, '0);
    chk("t4_sat_cnt", 64'(sat_cnt), 64'd40);

    // 5: manual clamp and mid-frame change ignored
    manual_shift = 5'd20;
    tick(1'b1, 1'b0, '0);
    chk("t5_clamp", 64'(shift_used), 64'd16);
    manual_shift = 5'd3;
    tick(1'b0, 1'b1, rep4(32'h0000_1234));
    tick(1'b0, 1'b1, rep4(32'h0004_0000));
    chk("t5_hold", 64'(shift_used), 64'd16);
    tick(1'b1, 1'b0, '0);
    chk("t5_new", 64'(shift_used), 64'd3);

    // 6: ms sample belongs to the new frame; back-to-back ms; async reset
    mode_auto = 1'b1;
    tick(1'b0, 1'b1, {32'h0, 32'h0, 32'h0300_0000, 32'h0});
    tick(1'b1, 1'b1, rep4(32'h0000_0100));
    chk("t6_max_old", 64'(max_out), 64'h0300_0000);
    tick(1'b1, 1'b0, '0);
    chk("t6_max_new", 64'(max_out), 64'h0000_0100);
    tick(1'b1, 1'b0, '0);
    chk("t6_max_empty", 64'(max_out), 64'h0);
    tick(1'b0, 1'b1, rep4(32'h1234_5678));
    tick(1'b0, 1'b1, rep4(32'h0000_5678));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_data", bus_if.data_out, 64'h0);
    chk("t6_arst_en", 64'(bus_if.en_sync_out), 64'd0);
    chk("t6_arst_cnt", 64'(bus_if.cnt_sync_out), 64'd0);
    chk("t6_arst_max", 64'(max_out), 64'h0);
    chk("t6_arst_valid", 64'(max_valid), 64'd0);
    chk("t6_arst_shift", 64'(shift_used), 64'd16);
    chk("t6_arst_sat", 64'(sat_cnt), 64'd0);
    do_reset();

    // Randomized frames against the model
    for (int i = 0; i < 600; i++) begin
      logic [127:0] rd;
      if ($urandom_range(0, 7) == 0) mode_auto = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) manual_shift = 5'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++) rd[k*32 +: 32] = $urandom >> $urandom_range(0, 31);
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/digital_gain_agc.md
Name: digital_gain_agc

Overview:
Multi-channel, parametrised digital gain stage with frame-synchronous automatic gain control. It sits between the accumulator/FFT power output and the packetiser. Each frame it tracks the peak of all channels and derives a right-shift. It then applies that shift to the following frame, with saturation to OUT_W bits, and keeps the sync signals aligned to the data latency.

Parameters:
IN_W, 32, input sample width (unsigned)
OUT_W, 16, output sample width; OUT_W < IN_W
NCH, 4, parallel channels per clock
CNT_W, 9, sync counter width
SHIFT_W, 5, shift field width; must hold IN_W-OUT_W (SHIFT_MAX)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ms_in  in  1  frame-start pulse, 1 cycle
en_sync_in  in  1  sample-valid qualifier
cnt_sync_in  in  CNT_W  sample index
data_in  in  NCH*IN_W  channel k at bits [k*IN_W +: IN_W]
mode_auto  in  1  1 = auto shift, 0 = manual
manual_shift  in  SHIFT_W  requested shift in manual mode
data_out  out  NCH*OUT_W  scaled samples, same packing as data_in
en_sync_out  out  1  en_sync_in delayed 2
cnt_sync_out  out  CNT_W  cnt_sync_in delayed 2
max_out  out  IN_W  peak of the previous frame
max_valid  out  1  1-cycle pulse when max_out updates
shift_used  out  SHIFT_W  shift applied to the current frame
sat_cnt  out  16  saturated samples in the previous frame

Behaviour:
- Reset values: all outputs 0, except shift_used = SHIFT_MAX. Internal run_max = 0, sat_acc = 0, pipeline registers = 0.
- Datapath has 2-cycle latency.
  - S1 registers data_in, en, cnt and ms.
  - S2 computes each channel as (x >> shift_used), saturates to OUT_W, then registers.
  - en_sync_out and cnt_sync_out are always delayed exactly 2 cycles, regardless of enable.
- Peak tracker:
  - cyc_max = max over NCH channels of data_in, gated by en_sync_in (0 when en = 0).
  - ms_in = 0: run_max <= max(run_max, cyc_max).
  - ms_in = 1: max_out <= run_max; max_valid <= 1; run_max <= cyc_max. The sample arriving with ms_in belongs to the new frame.
- Shift update happens only on ms_in, so gain never changes mid-frame.
  - Auto: shift_used <= clamp(msb_index(run_max) + 1 - OUT_W, 0, SHIFT_MAX). run_max = 0 gives shift 0.
  - Manual: shift_used <= min(manual_shift, SHIFT_MAX).
  - A sample entering S1 in the ms_in cycle, and every later sample, uses the new shift.
- Saturation:
  - If the shifted value exceeds 2^OUT_W - 1, the output is all ones.
  - Each saturated channel-sample with en set at S2 counts.
  - sat_acc adds 0..NCH per cycle and saturates at 0xFFFF.
  - Frame attribution uses ms delayed 2 (ms_d2). On ms_d2, sat_cnt <= sat_acc and sat_acc <= that cycle's count.
- mode_auto and manual_shift are sampled only at ms_in. Changes between frame starts have no effect until the next one.
- ms_in is honoured while en_sync_in = 0.
- Back-to-back ms_in pulses give max_out = 0 for the empty frame.
- Asynchronous rst mid-frame clears all state immediately. The first frame after reset uses SHIFT_MAX.

Optional Feature:
GAIN_ROUND_EN
- Defined: round half-up before saturation. Output = (x >> s) + x[s-1] when s > 0. A carry past 2^OUT_W - 1 saturates and counts in sat_cnt. Latency unchanged.
- Undefined: truncation (plain shift).

Test Plan:
Default parameters apply (IN_W = 32, OUT_W = 16, NCH = 4).
1. Reset release, no ms_in, data 0xFFFF_FFFF on all channels with en = 1 -> shift_used = 16, data_out = 0xFFFF per channel 2 cycles after input, sat_cnt = 0, en/cnt outputs are 2-cycle delayed copies.
2. Auto mode, frame 1 peak 0x0001_2345 on channel 2, then ms_in; frame 2 data 0x0001_2345 -> max_out = 0x0001_2345, max_valid pulse, shift_used = 1, data_out = 0x91A2 (0x91A3 with GAIN_ROUND_EN).
3. Auto mode, frame peaks 0x0000_8000, then 0, then 0xFFFF_FFFF -> shift_used 0, 0, 16 on successive frames.
4. Manual shift 4, data 0x0010_0000 on all 4 channels for 10 valid cycles, then ms_in -> data_out = 0xFFFF; 2 cycles after ms_in, sat_cnt = 40.
5. Manual shift 20 -> shift_used = 16. Changing manual_shift mid-frame leaves shift_used unchanged until the next ms_in.
6. ms_in and en = 1 with data 0x0000_0100 in the same cycle, previous run_max 0x0300_0000 -> max_out = 0x0300_0000; the new frame's run_max starts at 0x0000_0100. Assert rst mid-frame -> all outputs are reset within the same cycle.
